// File: rtl/sdram_dma_pkg.sv
// Shared definitions for the SDRAM AXI read-DMA: FSM state encoding,
// AXI constants, width constants and the 4 KB boundary helper.
package sdram_dma_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_REQ   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [11:0] AXI_4K_MASK    = 12'hFFF;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int WORDS_W = 24;
  localparam int LEN_W   = 8;
  localparam int ID_W    = 4;

  // Number of 32-bit words from a word-aligned address up to the next 4 KB page (1..1024).
  function automatic logic [10:0] words_to_4k(input logic [ADDR_W-1:0] addr);
    logic [12:0] bytes_left;
    bytes_left = 13'h1000 - {1'b0, addr[11:0] & AXI_4K_MASK};
    return bytes_left[12:2];
  endfunction

endpackage

// File: rtl/sdram_dma_fifo.sv
// Synchronous show-ahead FIFO used as the stream buffer of the read DMA.
// data_o shows the head word whenever the FIFO is non-empty and reads 0 otherwise.
module sdram_dma_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count;
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  // Storage write; no reset needed since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_axi_rd_dma.sv
// Read-DMA sequencer on the AXI4 AR/R channels of the SDRAM port.
// Fetches a linear block of words as INCR bursts (split at BURST_LEN and 4 KB pages)
// into a stream FIFO. A burst is requested only when all its beats already have FIFO
// space reserved, so R is never back-pressured while busy.
// Optional feature: define SDRAM_DMA_LOOP_EN to add loop_i (frame repeat from DRAIN).
// Handshake rule: a transfer on any channel happens on a rising clock edge where both
// valid and ready are high; valid payload stays stable until that edge.
module sdram_axi_rd_dma
  import sdram_dma_pkg::*;
#(
  parameter int         BURST_LEN  = 16,
  parameter int         FIFO_DEPTH = 64,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef SDRAM_DMA_LOOP_EN
  input  logic        loop_i,
`endif
  input  logic        start_i,
  input  logic [31:0] base_i,
  input  logic [23:0] words_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  output logic [3:0]  axi_arid_o,
  output logic [7:0]  axi_arlen_o,
  output logic [1:0]  axi_arburst_o,
  input  logic        axi_arready_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic [3:0]  axi_rid_i,
  input  logic        axi_rlast_i,
  output logic        axi_rready_o,
  output logic        m_valid_o,
  output logic [31:0] m_data_o,
  input  logic        m_ready_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [WORDS_W-1:0]  rem;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       out_next;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       credits;
  logic [10:0]         beats;
  logic [10:0]         to_4k;
  logic                credit_ok;
  logic                ar_hs;
  logic                r_push;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic                err_q;
  logic                done_q;
  logic                unused_bits;
`ifdef SDRAM_DMA_LOOP_EN
  logic [ADDR_W-1:0]   base_q;
  logic [WORDS_W-1:0]  words_q;
`endif

  // rlast is deliberately not cross-checked; beat accounting uses the outstanding count.
  assign unused_bits = ^{axi_rlast_i, base_i[1:0], fifo_full};

  // Burst size: the smallest of the burst limit, remaining words and room left in the 4 KB page.
  always_comb begin
    to_4k = words_to_4k(addr);
    beats = 11'(BURST_LEN);
    if (rem < WORDS_W'(BURST_LEN)) beats = rem[10:0];
    if (to_4k < beats)             beats = to_4k;
  end

  // Credits never shrink while a request waits, so arvalid stays up until arready.
  assign credits   = CW'(FIFO_DEPTH) - fifo_count - outstanding;
  assign credit_ok = (16'(credits) >= 16'(beats));

  assign busy_o        = (state != ST_IDLE);
  assign axi_rready_o  = busy_o;
  assign axi_arvalid_o = (state == ST_REQ) && credit_ok;
  assign axi_araddr_o  = addr;
  assign axi_arlen_o   = (state == ST_REQ) ? 8'(beats - 11'd1) : 8'd0;
  assign axi_arid_o    = AXI_ID;
  assign axi_arburst_o = AXI_BURST_INCR;
  assign done_o        = done_q;
  assign err_o         = err_q;

  assign ar_hs  = axi_arvalid_o && axi_arready_i;
  assign r_push = axi_rvalid_i && axi_rready_o && (axi_rid_i == AXI_ID);
  assign pop    = m_valid_o && m_ready_i;

  // Outstanding beats: AR handshake adds, accepted R beat removes, both in the same cycle.
  always_comb begin
    out_next = outstanding;
    if (ar_hs)  out_next = out_next + CW'(beats);
    if (r_push) out_next = out_next - CW'(1);
  end

  // FSM, address generator, beat accounting, sticky error and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      addr        <= '0;
      rem         <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef SDRAM_DMA_LOOP_EN
      base_q      <= '0;
      words_q     <= '0;
`endif
    end else begin
      outstanding <= out_next;
      done_q      <= ((state == ST_IDLE) && start_i && (words_i == '0)) ||
                     ((state == ST_DRAIN) && (outstanding == '0));
      if (r_push && (axi_rresp_i != 2'b00)) err_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            addr  <= {base_i[31:2], 2'b00};
            rem   <= words_i;
            err_q <= 1'b0;
`ifdef SDRAM_DMA_LOOP_EN
            base_q  <= {base_i[31:2], 2'b00};
            words_q <= words_i;
`endif
            state <= (words_i == '0) ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (ar_hs) begin
            addr <= addr + ADDR_W'({beats, 2'b00});
            rem  <= rem - WORDS_W'(beats);
            if (rem == WORDS_W'(beats)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
`ifdef SDRAM_DMA_LOOP_EN
            if (loop_i) begin
              addr  <= base_q;
              rem   <= words_q;
              state <= ST_REQ;
            end else begin
              state <= ST_DONE;
            end
`else
            state <= ST_DONE;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sdram_dma_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (r_push),
    .data_i  (axi_rdata_i),
    .pop_i   (pop),
    .data_o  (m_data_o),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign m_valid_o = !fifo_empty;

endmodule

// File: tb/tb_sdram_axi_rd_dma.sv
// Bench for sdram_axi_rd_dma: directed transfers against a small AXI read slave,
// with expected AR requests and stream words queued at stimulus time and checked
// by an independent monitor.
module tb_sdram_axi_rd_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic [23:0] words;
  logic        busy, done, err;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  logic        rready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
`ifdef SDRAM_DMA_LOOP_EN
  logic        loop_en;
`endif

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ar_cnt = 0;
  int stall_cnt = 0;

  logic [31:0] exp_q[$];
  logic [39:0] exp_ar_q[$];
  logic [39:0] slv_q[$];

  logic        stray_pend = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  // clock / reset
  always #5 clk = ~clk;

  sdram_axi_rd_dma #(.BURST_LEN(16), .FIFO_DEPTH(64), .AXI_ID(4'd0)) dut (
    .clk_i(clk), .rst_i(rst),
`ifdef SDRAM_DMA_LOOP_EN
    .loop_i(loop_en),
`endif
    .start_i(start), .base_i(base), .words_i(words),
    .busy_o(busy), .done_o(done), .err_o(err),
    .axi_arvalid_o(arvalid), .axi_araddr_o(araddr), .axi_arid_o(arid),
    .axi_arlen_o(arlen), .axi_arburst_o(arburst), .axi_arready_i(arready),
    .axi_rvalid_i(rvalid), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
    .axi_rid_i(rid), .axi_rlast_i(rlast), .axi_rready_o(rready),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver helpers
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] len);
    exp_ar_q.push_back({a, len});
  endtask

  task automatic push_words(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(data_of(b + 32'(4 * i)));
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [23:0] w);
    base  = b;
    words = w;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      cycles(1);
      k++;
    end
    check(name, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      cycles(1);
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // AXI read slave: samples handshakes at negedge, updates drive just after posedge.
  initial begin
    logic        r_fire, ar_fire;
    logic [3:0]  r_id_s;
    logic [39:0] ar_pl, pl;
    logic [31:0] s_addr;
    int          s_left;
    rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b0;
    s_addr = '0;
    s_left = 0;
    forever begin
      @(negedge clk);
      r_fire  = rvalid && rready;
      r_id_s  = rid;
      ar_fire = arvalid && arready;
      ar_pl   = {araddr, arlen};
      @(posedge clk);
      #1;
      if (rst) begin
        s_left = 0;
        slv_q.delete();
      end else begin
        if (ar_fire) slv_q.push_back(ar_pl);
        if (r_fire) begin
          if (r_id_s != 4'd0) stray_pend = 1'b0;
          else begin
            s_left--;
            s_addr += 32'd4;
          end
        end
        if (s_left == 0 && slv_q.size() > 0) begin
          pl     = slv_q.pop_front();
          s_addr = pl[39:8];
          s_left = int'(pl[7:0]) + 1;
        end
      end
      if (s_left > 0 && stray_pend) begin
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00; rid = 4'd5; rlast = 1'b1;
      end else if (s_left > 0) begin
        rvalid = 1'b1; rdata = data_of(s_addr); rid = 4'd0;
        rresp  = (s_addr == err_addr) ? 2'b10 : 2'b00;
        rlast  = (s_left == 1);
      end else begin
        rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic        ar_wait, prev_done;
    logic [39:0] held, e_ar;
    logic [31:0] e;
    ar_wait = 1'b0;
    prev_done = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) check("stream_unexpected_word", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            check("stream_data", 64'(m_data), 64'(e));
          end
        end
        if (ar_wait) begin
          check("ar_hold_valid", 64'(arvalid), 64'd1);
          check("ar_hold_payload", 64'({araddr, arlen}), 64'(held));
        end
        ar_wait = arvalid && !arready;
        held    = {araddr, arlen};
        if (arvalid && arready) begin
          ar_cnt++;
          if (exp_ar_q.size() == 0) check("ar_unexpected", 64'({araddr, arlen}), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e_ar = exp_ar_q.pop_front();
            check("ar_addr", 64'(araddr), 64'(e_ar[39:8]));
            check("ar_len", 64'(arlen), 64'(e_ar[7:0]));
          end
        end
        if (rvalid && !rready) stall_cnt++;
        if (done) begin
          done_cnt++;
          if (prev_done) check("done_width", 64'd2, 64'd1);
        end
        prev_done = done;
      end
    end
  end

  // directed stimulus
  initial begin
    int d0, a0;
    logic d1, d2, d3;
    rst = 1'b1; start = 1'b0; base = '0; words = '0; arready = 1'b1; m_ready = 1'b1;
`ifdef SDRAM_DMA_LOOP_EN
    loop_en = 1'b0;
`endif
    cycles(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_arid", 64'(arid), 64'd0);
    check("rst_arburst", 64'(arburst), 64'd1);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    rst = 1'b0;
    cycles(2);

    // three bursts from 0x100, with a foreign-ID beat slipped in first
    d0 = done_cnt;
    push_ar(32'h100, 8'd15); push_ar(32'h140, 8'd15); push_ar(32'h180, 8'd7);
    push_words(32'h100, 40);
    stray_pend = 1'b1;
    start_xfer(32'h100, 24'd40);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done(d0 + 1, 300, "a_done_timeout");
    wait_drain(300, "a_drain");
    cycles(3);
    check("a_done_count", 64'(done_cnt - d0), 64'd1);
    check("a_err_clean", 64'(err), 64'd0);

    // 4 KB page split, with AR held off for a few cycles
    d0 = done_cnt;
    push_ar(32'hFF8, 8'd1); push_ar(32'h1000, 8'd5);
    push_words(32'hFF8, 8);
    arready = 1'b0;
    start_xfer(32'hFF9, 24'd8);
    cycles(4);
    check("b_arvalid_waiting", 64'(arvalid), 64'd1);
    arready = 1'b1;
    wait_done(d0 + 1, 200, "b_done_timeout");
    wait_drain(200, "b_drain");

    // consumer stalled: only 64 words may be requested
    d0 = done_cnt;
    a0 = ar_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_ar(32'h2000 + 32'(64 * i), 8'd15);
    push_ar(32'h2180, 8'd3);
    push_words(32'h2000, 100);
    start_xfer(32'h2000, 24'd100);
    cycles(150);
    check("c_ar_count_stalled", 64'(ar_cnt - a0), 64'd4);
    check("c_arvalid_blocked", 64'(arvalid), 64'd0);
    check("c_m_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    wait_done(d0 + 1, 600, "c_done_timeout");
    wait_drain(300, "c_drain");
    check("c_ar_count_total", 64'(ar_cnt - a0), 64'd7);

    // error response is sticky until the next accepted start
    d0 = done_cnt;
    push_ar(32'h3000, 8'd3);
    push_words(32'h3000, 4);
    err_addr = 32'h3008;
    start_xfer(32'h3000, 24'd4);
    wait_done(d0 + 1, 200, "d_done_timeout");
    check("d_err_at_done", 64'(err), 64'd1);
    wait_drain(200, "d_drain");
    cycles(5);
    check("d_err_sticky", 64'(err), 64'd1);
    err_addr = 32'hFFFF_FFFF;

    // zero-length transfer: done two cycles after start, no AR, error cleared
    a0 = ar_cnt;
    d0 = done_cnt;
    base = 32'h0; words = 24'd0; start = 1'b1;
    @(negedge clk); d1 = done;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); d2 = done;
    check("z_err_cleared", 64'(err), 64'd0);
    check("z_busy", 64'(busy), 64'd1);
    @(negedge clk); d3 = done;
    check("z_done_c1", 64'(d1), 64'd0);
    check("z_done_c2", 64'(d2), 64'd1);
    check("z_done_c3", 64'(d3), 64'd0);
    cycles(3);
    check("z_no_ar", 64'(ar_cnt - a0), 64'd0);
    check("z_done_count", 64'(done_cnt - d0), 64'd1);
    check("z_idle", 64'(busy), 64'd0);

    // start held while busy with other parameters must be ignored
    d0 = done_cnt;
    push_ar(32'h4000, 8'd15); push_ar(32'h4040, 8'd3);
    push_words(32'h4000, 20);
    start_xfer(32'h4000, 24'd20);
    base = 32'h9000; words = 24'd5; start = 1'b1;
    cycles(4);
    start = 1'b0;
    wait_done(d0 + 1, 200, "e_done_timeout");
    wait_drain(200, "e_drain");
    cycles(3);
    check("e_done_count", 64'(done_cnt - d0), 64'd1);

`ifdef SDRAM_DMA_LOOP_EN
    // frame repeat: three passes over the same 16 words without visiting IDLE
    d0 = done_cnt;
    for (int p = 0; p < 3; p++) begin
      push_ar(32'h5000, 8'd15);
      push_words(32'h5000, 16);
    end
    loop_en = 1'b1;
    start_xfer(32'h5000, 24'd16);
    wait_done(d0 + 2, 300, "l_done2_timeout");
    check("l_busy_between", 64'(busy), 64'd1);
    loop_en = 1'b0;
    wait_done(d0 + 3, 300, "l_done3_timeout");
    wait_drain(200, "l_drain");
    check("l_done_count", 64'(done_cnt - d0), 64'd3);
`endif

    cycles(5);
    check("end_stream_queue", 64'(exp_q.size()), 64'd0);
    check("end_ar_queue", 64'(exp_ar_q.size()), 64'd0);
    check("end_r_stalls", 64'(stall_cnt), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
